// File: rtl/bsg_sdr_token_credit_tx.sv
// Transmit endpoint of the SDR token-credit link: registers core words onto the link and spends
// one receiver credit per word, recovering credits from the receiver's token toggle wire.
// Optional macro BSG_SDR_TOKEN_TX_OVERFLOW_CHECK_EN builds the sticky credit-overflow flag.
module bsg_sdr_token_credit_tx #(
    parameter int unsigned width_p                         = 16,
    parameter int unsigned lg_fifo_depth_p                 = 3,
    parameter int unsigned lg_credit_to_token_decimation_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    output logic [width_p-1:0]         link_data_o,
    output logic                       link_v_o,
    input  logic                       link_token_i,
    output logic [lg_fifo_depth_p:0]   credits_o,
    output logic                       err_overflow_o
);

    localparam int unsigned CredW = lg_fifo_depth_p + 1;
    localparam int unsigned CalcW = lg_fifo_depth_p + 2;
    localparam logic [CalcW-1:0] FullCredits  = CalcW'(1) << lg_fifo_depth_p;
    localparam logic [CalcW-1:0] TokenCredits = CalcW'(1) << lg_credit_to_token_decimation_p;

    logic [CredW-1:0]   credits_q, credits_d;
    logic               tok_s1_q, tok_s2_q, tok_p_q;
    logic               link_v_q;
    logic [width_p-1:0] link_data_q;
    logic               send, ret, overflow;
    logic [CalcW-1:0]   nxt;

    assign ready_and_o = ~reset_i & (credits_q != '0);
    assign send        = v_i & ready_and_o;
    // Only rising token edges return credits.
    assign ret         = tok_s2_q & ~tok_p_q;

    always_comb begin
        nxt       = CalcW'(credits_q) - CalcW'(send) + (ret ? TokenCredits : '0);
        overflow  = nxt > FullCredits;
        credits_d = overflow ? FullCredits[CredW-1:0] : nxt[CredW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q   <= FullCredits[CredW-1:0];
            tok_s1_q    <= 1'b0;
            tok_s2_q    <= 1'b0;
            tok_p_q     <= 1'b0;
            link_v_q    <= 1'b0;
            link_data_q <= '0;
        end else begin
            credits_q <= credits_d;
            tok_s1_q  <= link_token_i;
            tok_s2_q  <= tok_s1_q;
            tok_p_q   <= tok_s2_q;
            link_v_q  <= send;
            if (send) begin
                link_data_q <= data_i;
            end
        end
    end

    assign link_v_o    = link_v_q;
    assign link_data_o = link_data_q;
    assign credits_o   = credits_q;

`ifdef BSG_SDR_TOKEN_TX_OVERFLOW_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (overflow) begin
            err_q <= 1'b1;
        end
    end

    assign err_overflow_o = err_q;

`ifndef SYNTHESIS
    logic [63:0] cycle_q;

    always_ff @(posedge clk_i) begin
        cycle_q <= reset_i ? '0 : cycle_q + 64'd1;
        if (!reset_i && overflow) begin
            $error("bsg_sdr_token_credit_tx: credit overflow at cycle %0d", cycle_q);
        end
    end
`endif
`else
    assign err_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_sdr_token_credit_tx.sv
// Bench for bsg_sdr_token_credit_tx: directed vector table, a reset-mid-stream sequence, and
// randomized traffic against a delay-line credit model.
module tb_bsg_sdr_token_credit_tx;

    localparam int W        = 16;
    localparam int LG       = 3;
    localparam int DEC      = 1;
    localparam int FULL     = 8;
    localparam int TOK_CRED = 2;
`ifdef BSG_SDR_TOKEN_TX_OVERFLOW_CHECK_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i, v_i, link_token_i;
    logic [W-1:0]  data_i;
    logic          ready_and_o, link_v_o, err_overflow_o;
    logic [W-1:0]  link_data_o;
    logic [LG:0]   credits_o;

    int n_checks = 0;
    int n_errors = 0;

    bsg_sdr_token_credit_tx #(
        .width_p                        (W),
        .lg_fifo_depth_p                (LG),
        .lg_credit_to_token_decimation_p(DEC)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .data_i        (data_i),
        .v_i           (v_i),
        .ready_and_o   (ready_and_o),
        .link_data_o   (link_data_o),
        .link_v_o      (link_v_o),
        .link_token_i  (link_token_i),
        .credits_o     (credits_o),
        .err_overflow_o(err_overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         v;
        logic         tok;
        logic [W-1:0] data;
        int           credits;
        logic         ready;
        logic         lv;
        logic [W-1:0] ld;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic v, logic tok, logic [W-1:0] data, int credits,
                                logic ready, logic lv, logic [W-1:0] ld, logic ovf);
        vec_t e;
        e.rst = rst; e.v = v; e.tok = tok; e.data = data; e.credits = credits;
        e.ready = ready; e.lv = lv; e.ld = ld; e.ovf = ovf;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step(input logic rst, input logic v, input logic tok, input logic [W-1:0] d);
        reset_i = rst; v_i = v; link_token_i = tok; data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int cred, input logic rdy, input logic lv,
                           input logic [W-1:0] ld, input logic ovf);
        chk({tag, " credits_o"}, int'(credits_o), cred);
        chk({tag, " ready_and_o"}, int'(ready_and_o), int'(rdy));
        chk({tag, " link_v_o"}, int'(link_v_o), int'(lv));
        chk({tag, " link_data_o"}, int'(link_data_o), int'(ld));
        chk({tag, " err_overflow_o"}, int'(err_overflow_o), int'(OvfEn & ovf));
    endtask

    // Reference model: token samples per edge, credits as a plain integer.
    int           m_cred;
    logic         m_lv;
    logic [W-1:0] m_ld;
    bit           m_ovf;
    bit           tok_hist[$];

    task automatic model_edge(input logic rst, input logic v, input logic tok,
                              input logic [W-1:0] d);
        bit send, ret;
        int nxt;
        send = v && !rst && (m_cred != 0);
        if (rst) begin
            m_cred = FULL; m_lv = 1'b0; m_ld = '0; m_ovf = 1'b0;
            tok_hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            // A rise between the samples taken three and two edges ago lands now.
            ret = tok_hist[1] && !tok_hist[0];
            void'(tok_hist.pop_front());
            tok_hist.push_back(tok);
            nxt = m_cred - int'(send) + (ret ? TOK_CRED : 0);
            if (nxt > FULL) begin
                nxt   = FULL;
                m_ovf = 1'b1;
            end
            m_cred = nxt;
            m_lv   = send;
            if (send) m_ld = d;
        end
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; link_token_i = 1'b0; data_i = '0;

        // Reset, then exhaust all eight credits.
        add(1, 0, 0, 16'h0, 8, 0, 0, 16'h0, 0);
        add(1, 0, 0, 16'h0, 8, 0, 0, 16'h0, 0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 1, 0, W'(k), 8 - k, (k != 8), 1, W'(k), 0);
        end
        add(0, 1, 0, 16'h9, 0, 0, 0, 16'h8, 0);
        // Token rise returns two credits three edges later; the fall does nothing.
        add(0, 0, 1, 16'h0, 0, 0, 0, 16'h8, 0);
        add(0, 0, 1, 16'h0, 0, 0, 0, 16'h8, 0);
        add(0, 0, 1, 16'h0, 2, 1, 0, 16'h8, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 16'h0, 2, 1, 0, 16'h8, 0);
        add(0, 0, 1, 16'h0, 2, 1, 0, 16'h8, 0);
        add(0, 0, 1, 16'h0, 2, 1, 0, 16'h8, 0);
        add(0, 0, 1, 16'h0, 4, 1, 0, 16'h8, 0);
        // Send and token return on the same edge from three credits.
        add(0, 1, 0, 16'hA, 3, 1, 1, 16'hA, 0);
        add(0, 0, 0, 16'h0, 3, 1, 0, 16'hA, 0);
        add(0, 0, 1, 16'h0, 3, 1, 0, 16'hA, 0);
        add(0, 0, 1, 16'h0, 3, 1, 0, 16'hA, 0);
        add(0, 1, 1, 16'hB, 4, 1, 1, 16'hB, 0);
        // Token rise at full credits saturates.
        add(1, 0, 0, 16'h0, 8, 0, 0, 16'h0, 0);
        add(0, 0, 1, 16'h0, 8, 1, 0, 16'h0, 0);
        add(0, 0, 1, 16'h0, 8, 1, 0, 16'h0, 0);
        add(0, 0, 1, 16'h0, 8, 1, 0, 16'h0, 1);
        add(0, 0, 1, 16'h0, 8, 1, 0, 16'h0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].tok, vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].credits, vecs[i].ready, vecs[i].lv,
                    vecs[i].ld, vecs[i].ovf);
        end

        // Reset mid-stream with credits at five.
        step(0, 1, 1, 16'h10);
        step(0, 1, 1, 16'h11);
        step(0, 1, 1, 16'h12);
        chk_all("mid pre", 5, 1, 1, 16'h12, 1);
        step(1, 1, 0, 16'h13);
        chk_all("mid rst", 8, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0);
        chk_all("mid post", 8, 1, 0, 16'h0, 0);

        // Randomized traffic against the model.
        begin
            logic r, v, t;
            logic [W-1:0] d;
            t = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                r = (c < 2) || ($urandom_range(0, 299) == 0);
                v = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) t = ~t;
                d = W'($urandom);
                model_edge(r, v, t, d);
                step(r, v, t, d);
                chk_all($sformatf("rnd%0d", c), m_cred, !r && (m_cred != 0), m_lv, m_ld, m_ovf);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
